// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_hazard_ctrl
//  Purpose  : Load-use / ID-branch-compare hazard detection with stall FSM
//             and saturating stall-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_Branch,
    input  logic             id_UsesRt,
    input  logic [4:0]       if_id_RegisterRs,
    input  logic [4:0]       if_id_RegisterRt,
    input  logic             id_ex_RegWrite,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_RegisterRd,
    input  logic             ex_mem_MemRead,
    input  logic [4:0]       ex_mem_RegisterRd,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0]       c_IDLE    = 1'b0;
    localparam logic [0:0]       c_STALL   = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_nextState;
    logic             w_matchE;
    logic             w_matchM;
    logic [1:0]       w_needN;
    logic             w_stall;
    logic [CNT_W-1:0] r_stallCount;

    // Register 0 is hard-wired, so it can never be a pending producer.
    assign w_matchE = (id_ex_RegisterRd != 5'd0) &&
                      ((id_ex_RegisterRd == if_id_RegisterRs) ||
                       (id_UsesRt && (id_ex_RegisterRd == if_id_RegisterRt)));
    assign w_matchM = (ex_mem_RegisterRd != 5'd0) &&
                      ((ex_mem_RegisterRd == if_id_RegisterRs) ||
                       (id_UsesRt && (ex_mem_RegisterRd == if_id_RegisterRt)));

    // Checked longest-first so the largest required stall wins.
    always_comb begin
        w_needN = 2'd0;
        if (id_Branch && id_ex_MemRead && w_matchE) begin
            w_needN = 2'd2;
        end else if (id_Branch && id_ex_RegWrite && w_matchE) begin
            w_needN = 2'd1;
        end else if (id_Branch && ex_mem_MemRead && w_matchM) begin
            w_needN = 2'd1;
        end else if (!id_Branch && id_ex_MemRead && w_matchE) begin
            w_needN = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = c_IDLE;
        if (!flush) begin
            case (r_state)
                c_IDLE:  w_nextState = (w_needN == 2'd2) ? c_STALL : c_IDLE;
                c_STALL: w_nextState = c_IDLE;
                default: w_nextState = c_IDLE;
            endcase
        end
    end

    // Reset and flush both mask the stall so the pipeline is never frozen
    // on behalf of an instruction that is going away.
    always_comb begin
        w_stall = 1'b0;
        if (rst_n && !flush) begin
            case (r_state)
                c_IDLE:  w_stall = (w_needN != 2'd0);
                c_STALL: w_stall = 1'b1;
                default: w_stall = 1'b0;
            endcase
        end
        pc_write     = !w_stall;
        if_id_write  = !w_stall;
        id_ex_bubble = w_stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != c_CNT_MAX)) begin
            r_stallCount <= r_stallCount + c_CNT_ONE;
        end
    end

    assign stall_active = (r_state == c_STALL);
    assign stall_count  = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// Bench for branch_hazard_ctrl: vector table, corner sequences and random
// stimulus against a remaining-stall-cycles reference model.
module tb_branch_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, flush, br, usesRt, exRW, exMR, memMR;
    logic [4:0] rs, rt, exRd, memRd;
    logic       pcW, ifW, bub, act;
    logic       pcW2, ifW2, bub2, act2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    branch_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_Branch(br), .id_UsesRt(usesRt),
        .if_id_RegisterRs(rs), .if_id_RegisterRt(rt), .id_ex_RegWrite(exRW),
        .id_ex_MemRead(exMR), .id_ex_RegisterRd(exRd), .ex_mem_MemRead(memMR),
        .ex_mem_RegisterRd(memRd), .pc_write(pcW), .if_id_write(ifW),
        .id_ex_bubble(bub), .stall_active(act), .stall_count(cnt)
    );

    branch_hazard_ctrl #(.CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_Branch(br), .id_UsesRt(usesRt),
        .if_id_RegisterRs(rs), .if_id_RegisterRt(rt), .id_ex_RegWrite(exRW),
        .id_ex_MemRead(exMR), .id_ex_RegisterRd(exRd), .ex_mem_MemRead(memMR),
        .ex_mem_RegisterRd(memRd), .pc_write(pcW2), .if_id_write(ifW2),
        .id_ex_bubble(bub2), .stall_active(act2), .stall_count(cnt2)
    );

    int nChecks = 0;
    int nPass   = 0;
    int mRemain = 0;
    int mCnt    = 0;
    int mCnt2   = 0;
    logic sPc, sBub, sAct;
    int   sCnt, sCnt2;

    typedef struct {
        logic       br, usesRt, exRW, exMR, memMR, fl;
        logic [4:0] rs, rt, exRd, memRd;
        logic       expStall;
    } vec_t;
    vec_t vecs[13];
    int satExp[5];

    task automatic check(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) nPass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Required stall length, straight from the hazard rules.
    function automatic int modelN();
        int  n = 0;
        bit  mE, mM;
        mE = (exRd != 0) && ((exRd == rs) || (usesRt && exRd == rt));
        mM = (memRd != 0) && ((memRd == rs) || (usesRt && memRd == rt));
        if (br && exMR && mE)   n = (n > 2) ? n : 2;
        if (br && exRW && mE)   n = (n > 1) ? n : 1;
        if (br && memMR && mM)  n = (n > 1) ? n : 1;
        if (!br && exMR && mE)  n = (n > 1) ? n : 1;
        return n;
    endfunction

    task automatic setIdle();
        flush = 0; br = 0; usesRt = 0; exRW = 0; exMR = 0; memMR = 0;
        rs = 0; rt = 0; exRd = 0; memRd = 0;
    endtask

    // One clock cycle: sample and compare at negedge, then advance the model.
    task automatic cycle();
        int n;
        bit expStall;
        @(negedge clk);
        if (!rst_n) begin mRemain = 0; mCnt = 0; mCnt2 = 0; end
        n = modelN();
        expStall = rst_n && !flush && (mRemain > 0 || n > 0);
        sPc = pcW; sBub = bub; sAct = act; sCnt = int'(cnt); sCnt2 = int'(cnt2);
        check("pc_write",     int'(pcW),  expStall ? 0 : 1);
        check("if_id_write",  int'(ifW),  expStall ? 0 : 1);
        check("id_ex_bubble", int'(bub),  expStall ? 1 : 0);
        check("stall_active", int'(act),  (mRemain > 0) ? 1 : 0);
        check("stall_count",  int'(cnt),  mCnt);
        check("sat_count",    int'(cnt2), mCnt2);
        if (rst_n) begin
            if (flush)            mRemain = 0;
            else if (mRemain > 0) mRemain--;
            else                  mRemain = (n == 2) ? 1 : 0;
            if (expStall) begin
                if (mCnt < 65535) mCnt++;
                if (mCnt2 < 3)    mCnt2++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        setIdle();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0,0,0,1,0,0, 5, 0, 5, 0, 1};
        vecs[1]  = '{1,1,0,1,0,0, 1, 7, 7, 0, 1};
        vecs[2]  = '{1,0,1,0,0,0, 3, 0, 3, 0, 1};
        vecs[3]  = '{1,0,1,0,0,0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1,0,1,0,0,0, 1, 3, 3, 0, 0};
        vecs[5]  = '{1,1,0,0,1,0, 2, 9, 0, 9, 1};
        vecs[6]  = '{0,0,1,0,0,0, 4, 0, 4, 0, 0};
        vecs[7]  = '{0,0,0,0,1,0, 6, 0, 0, 6, 0};
        vecs[8]  = '{0,0,0,1,0,1, 5, 0, 5, 0, 0};
        vecs[9]  = '{1,0,0,0,0,0, 8, 0, 8, 0, 0};
        vecs[10] = '{0,1,0,1,0,0, 1,12,12, 0, 1};
        vecs[11] = '{1,0,0,0,1,0, 0, 0, 0, 0, 0};
        vecs[12] = '{0,0,0,1,0,0, 1,12,12, 0, 0};
        satExp   = '{1, 2, 3, 3, 3};

        // Reset with a live hazard on the inputs: stall outputs stay released.
        setIdle();
        rst_n = 0;
        exMR = 1; exRd = 5; rs = 5;
        cycle();
        check("reset_pc_write", int'(sPc), 1);
        check("reset_count",    sCnt, 0);
        cycle();
        setIdle();
        rst_n = 1;
        cycle();

        foreach (vecs[i]) begin
            br = vecs[i].br; usesRt = vecs[i].usesRt; exRW = vecs[i].exRW;
            exMR = vecs[i].exMR; memMR = vecs[i].memMR; flush = vecs[i].fl;
            rs = vecs[i].rs; rt = vecs[i].rt; exRd = vecs[i].exRd; memRd = vecs[i].memRd;
            cycle();
            check($sformatf("vec%0d_bubble", i), int'(sBub), int'(vecs[i].expStall));
            setIdle();
            flush = 1;
            cycle();
            flush = 0;
        end

        // Load-use, non-branch: one bubble, FSM never leaves IDLE.
        doReset();
        exMR = 1; exRd = 5; rs = 5;
        cycle();
        check("lu_pc",     int'(sPc),  0);
        check("lu_bubble", int'(sBub), 1);
        check("lu_active_after", int'(act), 0);
        check("lu_count_after",  int'(cnt), 1);

        // Load-then-branch: two stall cycles, second one from STALL.
        doReset();
        br = 1; exMR = 1; exRd = 7; rt = 7; usesRt = 1;
        cycle();
        check("lb_c0_pc",     int'(sPc),  0);
        check("lb_c0_active", int'(sAct), 0);
        cycle();
        check("lb_c1_pc",     int'(sPc),  0);
        check("lb_c1_active", int'(sAct), 1);
        setIdle();
        cycle();
        check("lb_c2_pc",     int'(sPc),  1);
        check("lb_c2_count",  sCnt, 2);

        // Flush in the STALL cycle cancels the remaining stall.
        doReset();
        br = 1; exMR = 1; exRd = 7; rt = 7; usesRt = 1;
        cycle();
        flush = 1;
        cycle();
        check("fl_pc",     int'(sPc),  1);
        check("fl_active", int'(sAct), 1);
        setIdle();
        cycle();
        check("fl_next_active", int'(sAct), 0);
        check("fl_next_count",  sCnt, 1);

        // Reset pulled low mid-STALL takes effect immediately.
        doReset();
        br = 1; exMR = 1; exRd = 7; rt = 7; usesRt = 1;
        cycle();
        rst_n = 0;
        #1;
        check("rs_pc_now",     int'(pcW), 1);
        check("rs_count_now",  int'(cnt), 0);
        check("rs_active_now", int'(act), 0);
        cycle();
        setIdle();
        rst_n = 1;
        cycle();
        check("rs_after_pc", int'(sPc), 1);

        // Saturation of the 2-bit counter under a continuous load-use hazard.
        doReset();
        exMR = 1; exRd = 5; rs = 5;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("sat%0d", k), int'(cnt2), satExp[k]);
        end

        // Random traffic against the model; small register range forces matches.
        doReset();
        for (int k = 0; k < 400; k++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            flush  = ($urandom_range(0, 9) == 0);
            br     = 1'($urandom);
            usesRt = 1'($urandom);
            exRW   = 1'($urandom);
            exMR   = 1'($urandom);
            memMR  = 1'($urandom);
            rs     = 5'($urandom_range(0, 3));
            rt     = 5'($urandom_range(0, 3));
            exRd   = 5'($urandom_range(0, 3));
            memRd  = 5'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
